// File: rtl/serial_add_acc.sv
// Bit-serial adder: consumes LSB-first propagate/generate pairs and assembles the sum.
// Optional signed-overflow output ovf_out is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             p_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             carry_out,
  output logic             ovf_out
`else
  output logic             carry_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             s, c_nxt, last;
  logic [WIDTH-1:0] sr_nxt;

  assign s      = p_in ^ c;
  assign c_nxt  = g_in | (p_in & c);
  assign sr_nxt = {s, sr[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      c         <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          c     <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (bit_valid) begin
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          sr  <= sr_nxt;
          // Result registers load on the same edge that enters DONE
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum_out   <= sr_nxt;
            carry_out <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
            ovf_out   <= c ^ c_nxt;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
